// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and defaults for the instruction-fetch stage
package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } fetch_state_e;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;

  function automatic word_t align_word(input word_t addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction-memory requester feeding the IF/ID register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  logic         req_q, req_d;
  word_t        pc4_q, pc4_d;
  word_t        instr_q, instr_d;
  logic         valid_q, valid_d;
  word_t        buf_pc4_q, buf_pc4_d;
  word_t        buf_instr_q, buf_instr_d;
  word_t        pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect outranks stall; a redirect with a response still outstanding must drain it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ_OFF: state_d = REQ;
      REQ: begin
        if (redirect) begin
          state_d = imem_ready ? REQ : DRAIN;
        end else if (imem_ready && stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_d = REQ;
        end
      end
      DRAIN: state_d = imem_ready ? REQ : DRAIN;
      default: state_d = REQ_OFF;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    buf_pc4_d   = buf_pc4_q;
    buf_instr_d = buf_instr_q;
    req_d       = (state_d == REQ);

    if (redirect) begin
      pc_d        = align_word(redirect_pc);
      pc4_d       = '0;
      instr_d     = NOP_WORD;
      valid_d     = 1'b0;
      buf_pc4_d   = '0;
      buf_instr_d = NOP_WORD;
    end else begin
      unique case (state_q)
        REQ: begin
          if (imem_ready && !stall) begin
            pc4_d   = pc_plus4;
            instr_d = imem_rdata;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else if (imem_ready) begin
            buf_pc4_d   = pc_plus4;
            buf_instr_d = imem_rdata;
          end else if (!stall) begin
            pc4_d   = '0;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc4_d   = buf_pc4_q;
            instr_d = buf_instr_q;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end
        DRAIN: begin
          pc4_d   = '0;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      pc4_q       <= '0;
      instr_q     <= NOP_WORD;
      valid_q     <= 1'b0;
      buf_pc4_q   <= '0;
      buf_instr_q <= NOP_WORD;
    end else begin
      pc_q        <= pc_d;
      req_q       <= req_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_pc_plus4 = pc4_q;
  assign if_instr    = instr_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .if_pc_plus4(if_pc_plus4),
    .if_instr(if_instr),
    .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] pc4, input logic [31:0] instr, input logic vld);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".pc4"},   if_pc_plus4, pc4);
    check({tag, ".instr"}, if_instr, instr);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, vld});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    tick(); tick();
    check_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    rst = 1'b0;
    tick();
    check_out("first_req", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);

    // async reset mid-request while ready pulses
    imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
    #2 rst = 1'b1;
    #1 check_out("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_out("ready_in_req_off", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);

    imem_ready = 1'b1; imem_rdata = 32'hA5A5_A5A5;
    tick();
    check_out("zw0", 1'b1, 32'h4, 32'h4, 32'hA5A5_A5A5, 1'b1);
    imem_rdata = 32'hA5A5_A5A1;
    tick();
    check_out("zw1", 1'b1, 32'h8, 32'h8, 32'hA5A5_A5A1, 1'b1);

    stall = 1'b1; imem_rdata = 32'hA5A5_A5AD;
    tick();
    check_out("hold0", 1'b0, 32'h8, 32'h8, 32'hA5A5_A5A1, 1'b1);
    imem_ready = 1'b0; imem_rdata = 32'h0BAD_0BAD;
    tick();
    check_out("hold1", 1'b0, 32'h8, 32'h8, 32'hA5A5_A5A1, 1'b1);
    stall = 1'b0;
    tick();
    check_out("unhold", 1'b1, 32'hC, 32'hC, 32'hA5A5_A5AD, 1'b1);

    tick();
    check_out("bubble", 1'b1, 32'hC, 32'h0, 32'h0, 1'b0);

    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    check_out("drain0", 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    redirect = 1'b0;
    tick();
    check_out("drain1", 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_out("drain_done", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);

    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103; imem_rdata = 32'h1234_5678;
    tick();
    check_out("redir_stall", 1'b1, 32'h100, 32'h0, 32'h0, 1'b0);
    redirect = 1'b0; imem_rdata = 32'h0000_0113;
    tick();
    check_out("stall_after", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
    stall = 1'b0; imem_ready = 1'b0;
    tick();
    check_out("release", 1'b1, 32'h104, 32'h104, 32'h0000_0113, 1'b1);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ready = 1'b1;
    tick();
    check_out("to_top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    redirect = 1'b0; imem_rdata = 32'hCAFE_F00D;
    tick();
    check_out("wrap", 1'b1, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
